// File: rtl/dragon_body_scheduler.sv
// Frame-paced step scheduler for a dragon: requests head moves, shifts the
// body segment history, tracks growth and reports player collisions.
module dragon_body_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       enable,
  input  logic [5:0] period,
  input  logic [7:0] head_pos,
  input  logic       step_ack,
  input  logic [7:0] player_pos,
  input  logic       grow,
  input  logic [2:0] seg_sel,
  output logic       step_req,
  output logic [7:0] seg_pos,
  output logic [2:0] body_len,
  output logic       collision,
  output logic       busy,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_WAIT, S_REQ, S_SHIFT, S_CHECK} state_t;

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic [5:0]  frm_cnt_q, frm_cnt_d;
  logic [3:0]  to_cnt_q, to_cnt_d;
  logic [3:0]  to_cnt_inc;
  logic        grow_pend_q, grow_pend_d;
  logic [7:0]  head_q, head_d;
  logic [7:0]  new_head_q, new_head_d;
  logic [7:0]  seg_q [0:6];
  logic [7:0]  seg_d [0:6];
  logic [2:0]  len_q, len_d;
  logic        coll_q, coll_d;
  logic        frame_tick;
  logic [5:0]  eff_period;
  logic        hit;

  assign frame_tick = vsync & ~vsync_q;
  assign eff_period = (period == 6'd0) ? 6'd1 : period;
  assign to_cnt_inc = to_cnt_q + 4'd1;

  // seg_q[k] holds body segment k+1; only the first len_q entries are live.
  always_comb begin
    hit = (player_pos == head_q);
    for (int k = 0; k < 7; k++) begin
      if ((3'(k) < len_q) && (seg_q[k] == player_pos)) hit = 1'b1;
    end
  end

  // Handshake: step_req stays high for every cycle spent in REQ; the head
  // mover answers with step_ack, sampled on the clock edge together with
  // head_pos. An ack seen outside REQ has no effect.
  always_comb begin
    state_d     = state_q;
    vsync_d     = vsync;
    frm_cnt_d   = frm_cnt_q;
    to_cnt_d    = to_cnt_q;
    grow_pend_d = grow_pend_q | grow;
    head_d      = head_q;
    new_head_d  = new_head_q;
    seg_d       = seg_q;
    len_d       = len_q;
    coll_d      = coll_q;
    case (state_q)
      S_WAIT: begin
        if (frame_tick && enable) begin
          if (frm_cnt_q == eff_period - 6'd1) begin
            frm_cnt_d = 6'd0;
            to_cnt_d  = 4'd0;
            state_d   = S_REQ;
          end else begin
            frm_cnt_d = frm_cnt_q + 6'd1;
          end
        end
      end
      S_REQ: begin
        if (step_ack) begin
          new_head_d = head_pos;
          to_cnt_d   = 4'd0;
          state_d    = S_SHIFT;
        end else if (to_cnt_inc == 4'd15) begin
          to_cnt_d = 4'd0;
          state_d  = S_WAIT;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end
      S_SHIFT: begin
        seg_d[0] = head_q;
        for (int k = 1; k < 7; k++) seg_d[k] = seg_q[k-1];
        head_d = new_head_q;
        if ((grow_pend_q || grow) && (len_q != 3'd7)) len_d = len_q + 3'd1;
        grow_pend_d = 1'b0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        coll_d  = hit;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_WAIT;
      vsync_q     <= 1'b0;
      frm_cnt_q   <= 6'd0;
      to_cnt_q    <= 4'd0;
      grow_pend_q <= 1'b0;
      head_q      <= 8'd0;
      new_head_q  <= 8'd0;
      for (int k = 0; k < 7; k++) seg_q[k] <= 8'd0;
      len_q       <= 3'd0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      frm_cnt_q   <= frm_cnt_d;
      to_cnt_q    <= to_cnt_d;
      grow_pend_q <= grow_pend_d;
      head_q      <= head_d;
      new_head_q  <= new_head_d;
      for (int k = 0; k < 7; k++) seg_q[k] <= seg_d[k];
      len_q       <= len_d;
      coll_q      <= coll_d;
    end
  end

  always_comb begin
    seg_pos = 8'hFF;
    if (seg_sel == 3'd0) seg_pos = head_q;
    else if (seg_sel <= len_q) seg_pos = seg_q[seg_sel - 3'd1];
  end

  // Status outputs are forced quiet while reset is held low.
  assign step_req  = reset & (state_q == S_REQ);
  assign busy      = reset & (state_q != S_WAIT);
  assign body_len  = reset ? len_q : 3'd0;
  assign collision = reset & coll_q;
  assign dbg_state = state_q;

endmodule
